// File: rtl/gray_conv_arbiter_pkg.sv
// Shared types and helpers for the Gray-converter arbiter.
package gca_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} gca_state_t;

  localparam int ID_W = 1;

  // Reference conversion on a 64-bit container. The caller truncates to its
  // width; zero-extension keeps the top bit of a narrower word unchanged.
  function automatic logic [63:0] bin2gray(input logic [63:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_conv_arbiter_bin2gray.sv
// Purely combinational W-bit binary-to-Gray converter.
module bin2gray_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] bin,
  output logic [W-1:0] gray
);

  // The MSB passes through. Every lower bit is the XOR of adjacent bits.
  always_comb begin
    gray[W-1] = bin[W-1];
    for (int k = 0; k < W - 1; k++) gray[k] = bin[k+1] ^ bin[k];
  end

endmodule

// File: rtl/gray_conv_arbiter.sv
// Two-requester round-robin arbiter in front of a single binary-to-Gray
// converter, with one registered valid/ready output stage.
// Optional per-requester accept counters when GCA_STATS_EN is defined.
module gray_conv_arbiter
  import gca_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  input  logic [W-1:0]    req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [W-1:0]    req1_data,
  output logic            req1_ready,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_gray,
  output logic [ID_W-1:0] out_id
`ifdef GCA_STATS_EN
  ,
  output logic [CNT_W-1:0] stat0_cnt,
  output logic [CNT_W-1:0] stat1_cnt
`endif
);

  // Elaboration-time parameter sanity checks.
  if (W < 2) begin : g_w_chk
    $error("gray_conv_arbiter: W must be >= 2");
  end
  if (CNT_W < 1) begin : g_cnt_w_chk
    $error("gray_conv_arbiter: CNT_W must be >= 1");
  end

  gca_state_t     state_q, state_d;
  logic [ID_W-1:0] last_grant;
  logic [ID_W-1:0] grant;
  logic           can_accept;
  logic           accept;
  logic [W-1:0]   mux_bin;
  logic [W-1:0]   mux_gray;

  // Round-robin pick. On a tie, the requester that did not win last time wins.
  always_comb begin
    grant = '0;
    if (req0_valid && !req1_valid)      grant = 1'b0;
    else if (req1_valid && !req0_valid) grant = 1'b1;
    else if (req0_valid && req1_valid)  grant = ~last_grant;
  end

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    can_accept = (state_q == EMPTY) || out_ready;
    req0_ready = rst_n && can_accept && req0_valid && (grant == 1'b0);
    req1_ready = rst_n && can_accept && req1_valid && (grant == 1'b1);
    accept     = req0_ready || req1_ready;
    mux_bin    = grant[0] ? req1_data : req0_data;
  end

  bin2gray_w #(.W(W)) u_conv (
    .bin  (mux_bin),
    .gray (mux_gray)
  );

  // Output-stage occupancy. FULL holds until the consumer drains it, unless
  // a new word is accepted in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (out_ready && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Output register and arbitration history. Both update only on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_gray   <= '0;
      out_id     <= '0;
      last_grant <= 1'b1;
    end else if (accept) begin
      out_gray   <= mux_gray;
      out_id     <= grant;
      last_grant <= grant;
    end
  end

  assign out_valid = (state_q == FULL);

`ifdef GCA_STATS_EN
  // Per-requester accept counters. They wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat0_cnt <= '0;
      stat1_cnt <= '0;
    end else begin
      if (req0_ready) stat0_cnt <= stat0_cnt + 1'b1;
      if (req1_ready) stat1_cnt <= stat1_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_gray_conv_arbiter.sv
// Directed self-checking bench for gray_conv_arbiter. Exercises the stats
// counters (CNT_W=4) when GCA_STATS_EN is defined.
module tb_gray_conv_arbiter;
  import gca_pkg::*;

  localparam int W = 8;
`ifdef GCA_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid, req1_valid, out_ready;
  logic [W-1:0] req0_data, req1_data;
  logic         req0_ready, req1_ready, out_valid;
  logic [W-1:0] out_gray;
  logic         out_id;
`ifdef GCA_STATS_EN
  logic [CNT_W-1:0] stat0_cnt, stat1_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  gray_conv_arbiter #(.W(W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_gray   (out_gray),
    .out_id     (out_id)
`ifdef GCA_STATS_EN
    ,
    .stat0_cnt  (stat0_cnt),
    .stat1_cnt  (stat1_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge, then settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_data  = '0;
    req1_data  = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();
    chk("rst_valid", out_valid, 0);
    chk("rst_gray", out_gray, 0);
    chk("rst_id", out_id, 0);

    // 1: single requester 0
    req0_valid = 1'b1; req0_data = 8'b11011101; #1;
    chk("t1_rdy0", req0_ready, 1);
    chk("t1_rdy1", req1_ready, 0);
    tick();
    req0_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_gray", out_gray, 8'b10110011);
    chk("t1_id", out_id, 0);
    tick();
    chk("t1_drain", out_valid, 0);

    // 2: tie after reset -> req0 first, then alternate
    do_reset();
    req0_valid = 1'b1; req0_data = 8'hAA;
    req1_valid = 1'b1; req1_data = 8'h66; #1;
    chk("t2_rdy0", req0_ready, 1);
    chk("t2_rdy1", req1_ready, 0);
    tick(); chk("t2_g0", out_gray, 8'hFF); chk("t2_i0", out_id, 0);
    chk("t2_r1next", req1_ready, 1);
    tick(); chk("t2_g1", out_gray, 8'h55); chk("t2_i1", out_id, 1);
    tick(); chk("t2_g2", out_gray, 8'hFF); chk("t2_i2", out_id, 0);
    tick(); chk("t2_g3", out_gray, 8'h55); chk("t2_i3", out_id, 1);

    // 3: backpressure while FULL
    out_ready = 1'b0; #1;
    chk("t3_rdy0", req0_ready, 0);
    chk("t3_rdy1", req1_ready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t3_hold_v", out_valid, 1);
      chk("t3_hold_g", out_gray, 8'h55);
      chk("t3_hold_i", out_id, 1);
    end
    out_ready = 1'b1; #1;
    chk("t3_resume_rdy0", req0_ready, 1);
    tick(); chk("t3_res_g", out_gray, 8'hFF); chk("t3_res_i", out_id, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick(); chk("t3_drain", out_valid, 0);

    // 4: back-to-back stream from req1
    req1_valid = 1'b1; req1_data = 8'h00; #1;
    chk("t4_rdy1", req1_ready, 1);
    tick(); chk("t4_g0", out_gray, 8'h00); chk("t4_i0", out_id, 1);
    req1_data = 8'hFF;
    tick(); chk("t4_v1", out_valid, 1); chk("t4_g1", out_gray, 8'h80);
    req1_data = 8'h99;
    tick(); chk("t4_g2", out_gray, 8'hD5); chk("t4_i2", out_id, 1);
    req1_valid = 1'b0;
    tick(); chk("t4_drain", out_valid, 0);

    // 5: async reset while FULL
    req1_valid = 1'b1; req1_data = 8'h12; out_ready = 1'b0;
    tick(); chk("t5_full", out_valid, 1);
    #2 rst_n = 1'b0; #1;
    chk("t5_async_v", out_valid, 0);
    chk("t5_async_g", out_gray, 0);
    chk("t5_rst_rdy1", req1_ready, 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b1; req0_data = 8'h0F; #1;
    chk("t5_tie_rdy0", req0_ready, 1);
    chk("t5_tie_rdy1", req1_ready, 0);
    tick(); chk("t5_g", out_gray, 8'h08); chk("t5_i", out_id, 0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();

`ifdef GCA_STATS_EN
    // 6: accept counters and wrap
    do_reset();
    chk("t6_rst0", stat0_cnt, 0);
    req0_valid = 1'b1; req0_data = 8'h01;
    for (int i = 0; i < 5; i++) tick();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_data = 8'h02;
    for (int i = 0; i < 3; i++) tick();
    req1_valid = 1'b0;
    tick();
    chk("t6_cnt0", stat0_cnt, 5);
    chk("t6_cnt1", stat1_cnt, 3);
    do_reset();
    req0_valid = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    chk("t6_cnt15", stat0_cnt, 15);
    tick();
    req0_valid = 1'b0;
    chk("t6_wrap", stat0_cnt, 0);
    tick();
`endif

    // Cross-check the package helper on a few words against hand values.
    chk("pkg_b2g", bin2gray(64'h99) & 64'hFF, 8'hD5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard stop in case anything above stalls.
  initial begin
    #100000;
    $display("FAIL timeout: got stalled expected finish");
    $fatal(1, "timeout");
  end

endmodule
